wb_result_queue: RTL and testbench
==================================

WB_RESULT_QUEUE -- requirements
Module: wb_result_queue

Interface
REQ-001 Parameter NCH, default 3: number of execution result channels (1..8).
REQ-002 Parameter DEPTH, default 4: entries per channel queue (power of two, 2..16).
REQ-003 Parameter DW, default 32: result data width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  discards all queued entries (mispredict recovery).
REQ-007 in_valid  in  NCH  per-channel result valid from the functional unit.
REQ-008 in_ready  out  NCH  per-channel accept; equals "queue not full".
REQ-009 in_res  in  NCH*DW  per-channel result, channel i at bits [i*DW +: DW].
REQ-010 in_rob / in_rd  in  NCH*6 each  ROB tag and physical destination register.
REQ-011 in_pc  in  NCH*12  instruction PC.
REQ-012 out_valid  out  NCH  per-channel head entry valid.
REQ-013 out_ready  in  NCH  per-channel consumer (ROB/CDB) accept.
REQ-014 out_res / out_rob / out_rd / out_pc  out  same packing as inputs  head entry fields.
REQ-015 occ  out  NCH*5  per-channel occupancy, 0..DEPTH.
REQ-016 ovf  out  NCH  sticky per-channel overflow flag.

Function
REQ-017 Push on channel i occurs when in_valid[i] and in_ready[i] are both high; pop when out_valid[i] and out_ready[i] are both high.
REQ-018 Channels are independent FIFOs; entries leave each channel in arrival order; no cross-channel ordering.
REQ-019 Without bypass, an entry pushed in cycle N is visible on the out_* fields in cycle N+1 at the earliest.
REQ-020 in_ready[i] depends only on stored state (occ[i] < DEPTH); a pop in the same cycle does not raise it.
REQ-021 Simultaneous push and pop on a non-empty, non-full channel leaves occ unchanged and preserves order.
REQ-022 in_valid[i] high while in_ready[i] low drops the entry, sets ovf[i] (held until reset), and leaves the queue unchanged.
REQ-023 out_* fields are held stable while out_valid[i] is high and out_ready[i] is low.
REQ-024 flush empties every channel the next cycle (occ=0, out_valid=0); a push in the flush cycle is discarded; ovf is unaffected.
REQ-025 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occ is tracked separately to distinguish full from empty.
REQ-026 When out_valid[i] is low, out_* data fields for that channel are don't-care.

Reset
REQ-027 While rst is high: all pointers and occ are 0, out_valid is 0, in_ready is all ones from the following cycle, and ovf is 0.
REQ-028 rst asserted mid-operation discards all queued entries; rst takes priority over flush, push and pop.

Configuration
REQ-029 Macro WBQ_BYPASS_EN enables the same-cycle bypass.
- Defined: when a channel is empty and in_valid[i] is high, out_valid[i] and out_* reflect the inputs combinationally in the same cycle.
- Defined: if out_ready[i] is also high, the entry is consumed without being stored and occ stays 0.
- Undefined: the latency of REQ-019 applies strictly.

Structure
REQ-030 Shared package wbq_pkg holds ROB_W=6, RD_W=6 and PC_W=12, plus the entry typedef {res, rob, rd, pc}.
REQ-031 Sub-module wbq_fifo is a single-channel FIFO of DEPTH entries with occ, full and empty; it is instantiated NCH times via generate.

Verification
REQ-032 Reset then single push ch0 res=0xDEADBEEF, rob=5 -> cycle+1: out_valid[0]=1, out_res=0xDEADBEEF, out_rob=5, occ[0]=1.
REQ-033 Order and full: push 4 entries 1..4 on ch1 with out_ready=0 -> occ[1]=4 and in_ready[1]=0; a 5th push sets ovf[1]; draining yields 1, 2, 3, 4.
REQ-034 Wrap-around: 10 push/pop cycles on ch2 with out_ready=1 -> outputs match the inputs in order and occ never exceeds 1.
REQ-035 Flush with ch0 holding 3 entries and a concurrent push -> next cycle occ=0 on all channels and the pushed entry never appears.
REQ-036 Bypass (WBQ_BYPASS_EN defined): empty ch0, push 0x1234 with out_ready=1 -> out_valid[0]=1 in the same cycle and occ[0] stays 0.
REQ-037 rst mid-drain with 2 entries queued -> next cycle out_valid=0, occ=0, ovf=0.

Source files
------------

// File: rtl/wbq_pkg.sv
// wbq_pkg: shared widths, occupancy width, the default result-entry layout and
// the occupancy update helper used by every write-back result queue channel.
//
// Contents:
//   ROB_W / RD_W / PC_W : ROB tag, physical destination and PC field widths
//   OCC_W               : occupancy counter width (holds 0..16)
//   DEF_DW              : result width of the default entry layout
//   wbq_entry_t         : {res, rob, rd, pc} entry with a DEF_DW-wide result
//   occ_next()          : occupancy after a (write, read) pair
package wbq_pkg;

    localparam int ROB_W  = 6;
    localparam int RD_W   = 6;
    localparam int PC_W   = 12;
    localparam int OCC_W  = 5;
    localparam int DEF_DW = 32;

    typedef struct packed {
        logic [DEF_DW-1:0] res;
        logic [ROB_W-1:0]  rob;
        logic [RD_W-1:0]   rd;
        logic [PC_W-1:0]   pc;
    } wbq_entry_t;

    // Simultaneous write and read leaves the count unchanged.
    function automatic logic [OCC_W-1:0] occ_next(
        input logic [OCC_W-1:0] occ,
        input logic             wr,
        input logic             rd
    );
        case ({wr, rd})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
    endfunction

endpackage

// File: rtl/wbq_fifo.sv
// wbq_fifo: single-channel FIFO of DEPTH entries for the write-back result queue.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO on the next edge, discarding a concurrent push
//   push       : write request, ignored while full
//   push_data  : entry to write
//   pop        : read request, ignored while empty
//   head       : oldest entry (meaningful only while !empty)
//   occ        : number of stored entries, 0..DEPTH
//   full/empty : derived from occ only
//
// Pointers are log2(DEPTH) bits and wrap naturally since DEPTH is a power of two;
// occ disambiguates full from empty when the pointers are equal.
module wbq_fifo
    import wbq_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wbq_entry_t
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [OCC_W-1:0] occ,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_s  = (occ_r == OCC_W'(DEPTH));
    assign empty_s = (occ_r == {OCC_W{1'b0}});
    assign wr_en_s = push && !full_s;
    assign rd_en_s = pop && !empty_s;

    // Pointer and occupancy state; reset wins over flush, flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_r <= {AW{1'b0}};
            rptr_r <= {AW{1'b0}};
            occ_r  <= {OCC_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            occ_r <= occ_next(occ_r, wr_en_s, rd_en_s);
        end
    end

    // Entry storage; contents need no reset because occ gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst && !flush) begin
            mem_r[wptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rptr_r];
    assign occ   = occ_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/wb_result_queue.sv
// wb_result_queue: NCH independent write-back result FIFOs sitting between the
// functional units and the ROB/CDB consumer.
//
// Ports (channel i occupies slice i of every packed vector):
//   clk, rst                  : clock, synchronous active-high reset
//   flush                     : mispredict recovery, empties every channel
//   in_valid / in_ready       : per-channel producer handshake (in_ready = not full)
//   in_res/in_rob/in_rd/in_pc : incoming result fields, DW/6/6/12 bits per channel
//   out_valid / out_ready     : per-channel consumer handshake
//   out_res/out_rob/out_rd/out_pc : head entry fields, don't-care while !out_valid
//   occ                       : per-channel occupancy, 5 bits per channel
//   ovf                       : sticky per-channel drop flag, cleared only by rst
//
// Build option: define WBQ_BYPASS_EN to let an empty channel present its input
// on the out_* fields in the same cycle; an entry taken that way is never stored.
module wb_result_queue
    import wbq_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic [NCH*DW-1:0]     in_res,
    input  logic [NCH*ROB_W-1:0]  in_rob,
    input  logic [NCH*RD_W-1:0]   in_rd,
    input  logic [NCH*PC_W-1:0]   in_pc,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*DW-1:0]     out_res,
    output logic [NCH*ROB_W-1:0]  out_rob,
    output logic [NCH*RD_W-1:0]   out_rd,
    output logic [NCH*PC_W-1:0]   out_pc,
    output logic [NCH*OCC_W-1:0]  occ,
    output logic [NCH-1:0]        ovf
);

    // Entry layout sized to this instance's result width.
    typedef struct packed {
        logic [DW-1:0]    res;
        logic [ROB_W-1:0] rob;
        logic [RD_W-1:0]  rd;
        logic [PC_W-1:0]  pc;
    } entry_t;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            entry_t           in_entry_s;
            entry_t           head_s;
            entry_t           out_entry_s;
            logic             full_s;
            logic             empty_s;
            logic             push_s;
            logic             pop_s;
            logic             out_valid_s;
            logic [OCC_W-1:0] occ_s;
            logic             ovf_r;

            assign in_entry_s.res = in_res[gi*DW +: DW];
            assign in_entry_s.rob = in_rob[gi*ROB_W +: ROB_W];
            assign in_entry_s.rd  = in_rd[gi*RD_W +: RD_W];
            assign in_entry_s.pc  = in_pc[gi*PC_W +: PC_W];

`ifdef WBQ_BYPASS_EN
            logic bypass_s;

            // An empty channel forwards its input; if the consumer takes it now it skips storage.
            assign bypass_s    = empty_s && in_valid[gi];
            assign out_valid_s = !empty_s || in_valid[gi];
            assign out_entry_s = bypass_s ? in_entry_s : head_s;
            assign push_s      = in_valid[gi] && !(bypass_s && out_ready[gi]);
`else
            assign out_valid_s = !empty_s;
            assign out_entry_s = head_s;
            assign push_s      = in_valid[gi];
`endif
            assign pop_s = out_ready[gi] && !empty_s;

            wbq_fifo #(
                .DEPTH   (DEPTH),
                .entry_t (entry_t)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .push      (push_s),
                .push_data (in_entry_s),
                .pop       (pop_s),
                .head      (head_s),
                .occ       (occ_s),
                .full      (full_s),
                .empty     (empty_s)
            );

            // Sticky drop flag: a valid offered while full is lost; flush leaves it alone.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (in_valid[gi] && full_s) begin
                    ovf_r <= 1'b1;
                end
            end

            // in_ready looks only at stored state, so a same-cycle pop never raises it.
            assign in_ready[gi]                 = !full_s;
            assign out_valid[gi]                = out_valid_s;
            assign out_res[gi*DW +: DW]         = out_entry_s.res;
            assign out_rob[gi*ROB_W +: ROB_W]   = out_entry_s.rob;
            assign out_rd[gi*RD_W +: RD_W]      = out_entry_s.rd;
            assign out_pc[gi*PC_W +: PC_W]      = out_entry_s.pc;
            assign occ[gi*OCC_W +: OCC_W]       = occ_s;
            assign ovf[gi]                      = ovf_r;
        end
    endgenerate

endmodule

// File: tb/tb_wb_result_queue.sv
`timescale 1ns/1ps
module tb_wb_result_queue;

    localparam int NCH   = 3;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*DW-1:0] in_res;
    logic [NCH*6-1:0]  in_rob;
    logic [NCH*6-1:0]  in_rd;
    logic [NCH*12-1:0] in_pc;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*DW-1:0] out_res;
    logic [NCH*6-1:0]  out_rob;
    logic [NCH*6-1:0]  out_rd;
    logic [NCH*12-1:0] out_pc;
    logic [NCH*5-1:0]  occ;
    logic [NCH-1:0]    ovf;

    always #5 clk = ~clk;

    wb_result_queue #(.NCH(NCH), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_rob    (in_rob),
        .in_rd     (in_rd),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_rob   (out_rob),
        .out_rd    (out_rd),
        .out_pc    (out_pc),
        .occ       (occ),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  rob;
        logic [5:0]  rd;
        logic [11:0] pc;
    } exp_t;

    exp_t sbq [NCH][$];
    bit   movf [NCH];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid  = '0;
        out_ready = '0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic drive(input int c, input logic [31:0] res, input logic [5:0] rob);
        in_valid[c]         = 1'b1;
        in_res[c*DW +: DW]  = res;
        in_rob[c*6 +: 6]    = rob;
        in_rd[c*6 +: 6]     = rob ^ 6'h2A;
        in_pc[c*12 +: 12]   = res[11:0] ^ 12'hF0F;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with inputs already set: checks outputs, updates the
    // scoreboard for this cycle's handshakes, then advances one clock.
    task automatic cycle();
        exp_t inp;
        exp_t hd;
        bit   byp;
        bit   exp_v;
        bit   acc;
        #1;
        for (int c = 0; c < NCH; c++) begin
            inp.res = in_res[c*DW +: DW];
            inp.rob = in_rob[c*6 +: 6];
            inp.rd  = in_rd[c*6 +: 6];
            inp.pc  = in_pc[c*12 +: 12];
            byp = 1'b0;
`ifdef WBQ_BYPASS_EN
            byp = (sbq[c].size() == 0) && in_valid[c];
`endif
            exp_v = (sbq[c].size() != 0) || byp;
            check($sformatf("out_valid[%0d]", c), out_valid[c], exp_v);
            check($sformatf("occ[%0d]", c), occ[c*5 +: 5], sbq[c].size());
            check($sformatf("in_ready[%0d]", c), in_ready[c], sbq[c].size() < DEPTH);
            check($sformatf("ovf[%0d]", c), ovf[c], movf[c]);
            if (exp_v) begin
                hd = byp ? inp : sbq[c][0];
                check($sformatf("out_res[%0d]", c), out_res[c*DW +: DW], hd.res);
                check($sformatf("out_rob[%0d]", c), out_rob[c*6 +: 6], hd.rob);
                check($sformatf("out_rd[%0d]", c), out_rd[c*6 +: 6], hd.rd);
                check($sformatf("out_pc[%0d]", c), out_pc[c*12 +: 12], hd.pc);
            end
            acc = in_valid[c] && (sbq[c].size() < DEPTH);
            if (in_valid[c] && !acc) movf[c] = 1'b1;
            if (!(byp && out_ready[c])) begin
                if (exp_v && out_ready[c] && !byp) void'(sbq[c].pop_front());
                if (acc) sbq[c].push_back(inp);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                sbq[c].delete();
                movf[c] = 1'b0;
            end else if (flush) begin
                sbq[c].delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_res = '0;
        in_rob = '0;
        in_rd  = '0;
        in_pc  = '0;
        idle();
        rst = 1'b1;
        repeat (2) tick();
        // state while rst is still held
        cycle();
        idle();
        cycle();

        // single push on ch0, visible the following cycle
        drive(0, 32'hDEADBEEF, 6'd5);
        cycle();
        idle();
        cycle();
        out_ready[0] = 1'b1;
        cycle();
        idle();
        cycle();

        // fill ch1, overflow on the fifth push, then drain in order
        for (int i = 1; i <= 4; i++) begin
            idle();
            drive(1, 32'(i), 6'(i));
            cycle();
        end
        idle();
        drive(1, 32'd5, 6'd5);
        cycle();
        idle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            idle();
            out_ready[1] = 1'b1;
            cycle();
        end

        // wrap-around streaming on ch2
        for (int i = 0; i < 10; i++) begin
            idle();
            out_ready[2] = 1'b1;
            drive(2, 32'hA000_0000 + 32'(i), 6'(i + 10));
            cycle();
            check("wrap_occ_max", occ[10 +: 5] <= 5'd1, 1'b1);
        end
        idle();
        out_ready[2] = 1'b1;
        cycle();

        // flush with three entries queued on ch0 and a concurrent push
        for (int i = 0; i < 3; i++) begin
            idle();
            drive(0, 32'hC0DE_0000 + 32'(i), 6'(i + 20));
            cycle();
        end
        idle();
        flush = 1'b1;
        drive(0, 32'h0000_0BAD, 6'd33);
        cycle();
        idle();
        out_ready = '1;
        cycle();
        cycle();

        // empty ch0, push with the consumer ready
        idle();
        out_ready[0] = 1'b1;
        drive(0, 32'h0000_1234, 6'd7);
        cycle();
        idle();
        out_ready[0] = 1'b1;
        cycle();

        // all channels concurrently with random handshakes
        for (int i = 0; i < 24; i++) begin
            idle();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) == 1) drive(c, $urandom, 6'($urandom_range(0, 63)));
                out_ready[c] = ($urandom_range(0, 2) != 0);
            end
            cycle();
        end
        for (int i = 0; i < 6; i++) begin
            idle();
            out_ready = '1;
            cycle();
        end

        // rst in the middle of draining two entries
        idle();
        drive(2, 32'h5555_0001, 6'd41);
        cycle();
        idle();
        drive(2, 32'h5555_0002, 6'd42);
        cycle();
        idle();
        out_ready[2] = 1'b1;
        cycle();
        idle();
        out_ready[2] = 1'b1;
        rst = 1'b1;
        cycle();
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
